// File: rtl/ibex_register_file_hw_mon.sv
// rtl/ibex_register_file_hw_mon.sv - FF register file with Hamming-weight/distance leakage monitor
// Window sums of the per-cycle metric are queued in a small FIFO drained by valid/ready.
module ibex_register_file_hw_mon #(
    parameter bit                    RV32E             = 1'b0,
    parameter int unsigned           DataWidth         = 32,
    parameter int unsigned           NumReadPorts      = 2,
    parameter bit                    DummyInstructions = 1'b0,
    parameter logic [DataWidth-1:0]  WordZeroVal       = '0,
    parameter int unsigned           WindowLen         = 16,
    parameter int unsigned           FifoDepth         = 4,
    localparam int unsigned          SW                = $clog2(WindowLen*DataWidth+1)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              dummy_instr_id_i,
    input  logic                              dummy_instr_wb_i,
    input  logic [NumReadPorts*5-1:0]         raddr_i,
    output logic [NumReadPorts*DataWidth-1:0] rdata_o,
    input  logic [4:0]                        waddr_a_i,
    input  logic [DataWidth-1:0]              wdata_a_i,
    input  logic                              we_a_i,
    input  logic                              mon_en_i,
    input  logic                              mon_clr_i,
    input  logic                              mon_mode_i,
    input  logic [4:0]                        mon_addr_i,
    output logic                              sample_valid_o,
    input  logic                              sample_ready_i,
    output logic [SW-1:0]                     sample_data_o,
    output logic                              overflow_o
);

    localparam int unsigned AW       = RV32E ? 4 : 5;
    localparam int unsigned NumWords = 2 ** AW;
    localparam int unsigned CW       = $clog2(WindowLen + 1);
    localparam int unsigned PTRW     = $clog2(FifoDepth);

    function automatic logic [SW-1:0] popcount(input logic [DataWidth-1:0] v);
        logic [SW-1:0] n;
        n = '0;
        for (int i = 0; i < DataWidth; i++) begin
            n = n + SW'(v[i]);
        end
        return n;
    endfunction

    // Element 0 only changes when dummy instructions are enabled; otherwise it is a constant flop.
    logic [DataWidth-1:0] rf_q [NumWords];
    logic [AW-1:0]        waddr;
    logic                 we_reg;
    logic                 we_dummy;
    logic [DataWidth-1:0] r0_rdata;

    assign waddr    = waddr_a_i[AW-1:0];
    assign we_reg   = we_a_i && (waddr != '0);
    assign we_dummy = DummyInstructions && we_a_i && dummy_instr_wb_i;
    assign r0_rdata = (DummyInstructions && dummy_instr_id_i) ? rf_q[0] : WordZeroVal;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumWords; i++) begin
                rf_q[i] <= WordZeroVal;
            end
        end else begin
            if (we_reg) begin
                rf_q[waddr] <= wdata_a_i;
            end
            if (we_dummy) begin
                rf_q[0] <= wdata_a_i;
            end
        end
    end

    for (genvar k = 0; k < NumReadPorts; k++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = raddr_i[5*k +: AW];
        assign rdata_o[DataWidth*k +: DataWidth] = (ra == '0) ? r0_rdata : rf_q[ra];
    end

    logic unused_hi;
    if (RV32E) begin : g_unused
        logic [NumReadPorts-1:0] unused_raddr_hi;
        for (genvar k = 0; k < NumReadPorts; k++) begin : g_bit
            assign unused_raddr_hi[k] = raddr_i[5*k+4];
        end
        assign unused_hi = ^{unused_raddr_hi, waddr_a_i[4], mon_addr_i[4]};
    end else begin : g_no_unused
        assign unused_hi = 1'b0;
    end

    typedef enum logic {IDLE, ACCUM} state_e;

    state_e        state_q, state_d;
    logic          mode_q, mode_d;
    logic [AW-1:0] maddr_q, maddr_d;
    logic [SW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          eff_mode;
    logic [AW-1:0] eff_addr;
    logic [SW-1:0] metric_hw, metric_hd, metric;
    logic [SW-1:0] sum;
    logic [CW-1:0] cnt_inc;
    logic          window_done;
    logic          push;

    // The first cycle of a window is measured with the live mode/address being latched.
    assign eff_mode  = (state_q == IDLE) ? mon_mode_i : mode_q;
    assign eff_addr  = (state_q == IDLE) ? mon_addr_i[AW-1:0] : maddr_q;
    assign metric_hw = (eff_addr == '0) ? popcount(WordZeroVal) : popcount(rf_q[eff_addr]);
    assign metric_hd = we_reg   ? popcount(rf_q[waddr] ^ wdata_a_i) :
                       we_dummy ? popcount(rf_q[0] ^ wdata_a_i) : '0;
    assign metric    = eff_mode ? metric_hd : metric_hw;

    assign sum         = ((state_q == ACCUM) ? acc_q : '0) + metric;
    assign cnt_inc     = ((state_q == ACCUM) ? cnt_q : '0) + CW'(1);
    assign window_done = (cnt_inc == CW'(WindowLen));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            maddr_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            maddr_q <= maddr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        maddr_d = maddr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        if (mon_clr_i || !mon_en_i) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            state_d = ACCUM;
            if ((state_q == IDLE) || window_done) begin
                mode_d  = mon_mode_i;
                maddr_d = mon_addr_i[AW-1:0];
            end
            if (window_done) begin
                push  = 1'b1;
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_inc;
            end
        end
    end

    logic [SW-1:0]   fifo_mem [FifoDepth];
    logic [PTRW-1:0] wr_ptr, rd_ptr;
    logic [PTRW:0]   fifo_cnt;
    logic            fifo_empty, fifo_full, pop, push_ok;

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == (PTRW+1)'(FifoDepth));
    assign pop        = !fifo_empty && sample_ready_i;
    assign push_ok    = push && (!fifo_full || pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            overflow_o <= 1'b0;
        end else if (mon_clr_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTRW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTRW'(1);
            end
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (PTRW+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (PTRW+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (push && fifo_full && !pop) begin
                overflow_o <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= sum;
        end
    end

    assign sample_valid_o = !fifo_empty;
    assign sample_data_o  = fifo_empty ? '0 : fifo_mem[rd_ptr];

endmodule

// File: tb/tb_ibex_register_file_hw_mon.sv
// tb/tb_ibex_register_file_hw_mon.sv - directed bench for ibex_register_file_hw_mon
module tb_ibex_register_file_hw_mon;

    localparam int DW = 32;
    localparam int WL = 16;
    localparam int SW = $clog2(WL*DW+1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          dummy_id = 1'b0;
    logic          dummy_wb = 1'b0;
    logic [9:0]    raddr = '0;
    logic [63:0]   rdata;
    logic [4:0]    waddr = '0;
    logic [31:0]   wdata = '0;
    logic          we = 1'b0;
    logic          mon_en = 1'b0;
    logic          mon_clr = 1'b0;
    logic          mon_mode = 1'b0;
    logic [4:0]    mon_addr = '0;
    logic          valid;
    logic          ready = 1'b0;
    logic [SW-1:0] sdata;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ibex_register_file_hw_mon dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .dummy_instr_id_i (dummy_id),
        .dummy_instr_wb_i (dummy_wb),
        .raddr_i          (raddr),
        .rdata_o          (rdata),
        .waddr_a_i        (waddr),
        .wdata_a_i        (wdata),
        .we_a_i           (we),
        .mon_en_i         (mon_en),
        .mon_clr_i        (mon_clr),
        .mon_mode_i       (mon_mode),
        .mon_addr_i       (mon_addr),
        .sample_valid_o   (valid),
        .sample_ready_i   (ready),
        .sample_data_o    (sdata),
        .overflow_o       (overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        waddr = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
    endtask

    task automatic run_window(input logic [4:0] a, input logic ready_last);
        mon_mode = 1'b0;
        mon_addr = a;
        mon_en   = 1'b1;
        for (int i = 0; i < WL; i++) begin
            ready = (i == WL-1) ? ready_last : 1'b0;
            tick();
        end
        ready  = 1'b0;
        mon_en = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        raddr = {5'd0, 5'd15};
        repeat (2) @(posedge clk);
        #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (sdata !== '0) begin errors++; $display("FAIL reset_data: got %0d expected 0", sdata); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        checks++; if (rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_read_write();
        raddr = {5'd0, 5'd15};
        waddr = 5'd15;
        wdata = 32'hFFFF_0000;
        we    = 1'b1;
        #1;
        checks++; if (rdata[31:0] !== 32'h0) begin errors++; $display("FAIL rw_same_cycle: got %h expected 00000000", rdata[31:0]); end
        tick();
        we = 1'b0;
        #1;
        checks++; if (rdata[31:0] !== 32'hFFFF_0000) begin errors++; $display("FAIL rw_x15: got %h expected ffff0000", rdata[31:0]); end
        checks++; if (rdata[63:32] !== 32'h0) begin errors++; $display("FAIL rw_x0: got %h expected 00000000", rdata[63:32]); end
        write_reg(5'd0, 32'hDEAD_BEEF);
        #1;
        checks++; if (rdata[63:32] !== 32'h0) begin errors++; $display("FAIL rw_x0_write: got %h expected 00000000", rdata[63:32]); end
    endtask

    task automatic test_hw_window();
        write_reg(5'd15, 32'h0000_00FF);
        mon_mode = 1'b0;
        mon_addr = 5'd15;
        ready    = 1'b1;
        mon_en   = 1'b1;
        repeat (WL-1) tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL hw_early: got valid %b expected 0", valid); end
        tick();
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL hw_valid: got %b expected 1", valid); end
        checks++; if (sdata !== SW'(128)) begin errors++; $display("FAIL hw_sum: got %0d expected 128", sdata); end
        mon_en = 1'b0;
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL hw_popped: got valid %b expected 0", valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL hw_overflow: got %b expected 0", overflow); end
    endtask

    task automatic test_hd_window();
        write_reg(5'd5, 32'h0F0F_0F0F);
        mon_mode = 1'b1;
        mon_addr = 5'd15;
        ready    = 1'b1;
        mon_en   = 1'b1;
        for (int i = 0; i < WL; i++) begin
            we = 1'b0;
            if (i == 3) begin waddr = 5'd5; wdata = 32'hF0F0_F0F0; we = 1'b1; end
            if (i == 8) begin waddr = 5'd0; wdata = 32'hFFFF_FFFF; we = 1'b1; end
            tick();
        end
        we = 1'b0;
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL hd_valid: got %b expected 1", valid); end
        checks++; if (sdata !== SW'(32)) begin errors++; $display("FAIL hd_sum: got %0d expected 32", sdata); end
        mon_en = 1'b0;
        raddr  = {5'd0, 5'd5};
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL hd_popped: got valid %b expected 0", valid); end
        checks++; if (rdata[31:0] !== 32'hF0F0_F0F0) begin errors++; $display("FAIL hd_x5: got %h expected f0f0f0f0", rdata[31:0]); end
        ready = 1'b0;
    endtask

    task automatic test_overflow();
        write_reg(5'd1, 32'h1);
        write_reg(5'd2, 32'h3);
        write_reg(5'd3, 32'h7);
        write_reg(5'd4, 32'hF);
        write_reg(5'd6, 32'h1F);
        run_window(5'd1, 1'b0);
        run_window(5'd2, 1'b0);
        run_window(5'd3, 1'b0);
        run_window(5'd4, 1'b0);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_full_no_flag: got %b expected 0", overflow); end
        run_window(5'd6, 1'b0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (valid !== 1'b1 || sdata !== SW'(16*(i+1))) begin
                errors++; $display("FAIL ovf_pop%0d: got valid %b data %0d expected valid 1 data %0d", i, valid, sdata, 16*(i+1));
            end
            tick();
        end
        ready = 1'b0;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ovf_drained: got valid %b expected 0", valid); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_overflow: got %b expected 0", overflow); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL clr_valid: got %b expected 0", valid); end
    endtask

    task automatic test_full_push_pop();
        run_window(5'd1, 1'b0);
        run_window(5'd2, 1'b0);
        run_window(5'd3, 1'b0);
        run_window(5'd4, 1'b0);
        run_window(5'd6, 1'b1);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL pp_no_overflow: got %b expected 0", overflow); end
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (valid !== 1'b1 || sdata !== SW'(16*(i+2))) begin
                errors++; $display("FAIL pp_pop%0d: got valid %b data %0d expected valid 1 data %0d", i, valid, sdata, 16*(i+2));
            end
            tick();
        end
        ready = 1'b0;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL pp_drained: got valid %b expected 0", valid); end
    endtask

    task automatic test_abort();
        mon_mode = 1'b0;
        mon_addr = 5'd15;
        mon_en   = 1'b1;
        repeat (7) tick();
        mon_en = 1'b0;
        repeat (2) tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL abort_no_sample: got valid %b expected 0", valid); end
        mon_addr = 5'd4;
        mon_en   = 1'b1;
        repeat (WL-1) tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL abort_fresh_early: got valid %b expected 0", valid); end
        tick();
        checks++; if (sdata !== SW'(64) || valid !== 1'b1) begin errors++; $display("FAIL abort_fresh_sum: got valid %b data %0d expected valid 1 data 64", valid, sdata); end
        mon_en = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        run_window(5'd1, 1'b0);
        checks++; if (valid !== 1'b1 || sdata !== SW'(64)) begin errors++; $display("FAIL ar_queued: got valid %b data %0d expected valid 1 data 64", valid, sdata); end
        mon_addr = 5'd15;
        mon_en   = 1'b1;
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        raddr = {5'd4, 5'd15};
        #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b expected 0", valid); end
        checks++; if (sdata !== '0) begin errors++; $display("FAIL ar_data: got %0d expected 0", sdata); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ar_overflow: got %b expected 0", overflow); end
        checks++; if (rdata !== 64'h0) begin errors++; $display("FAIL ar_regs: got %h expected 0", rdata); end
        mon_en = 1'b0;
        #2;
        rst_n = 1'b1;
        repeat (2) tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ar_after: got valid %b expected 0", valid); end
    endtask

    initial begin
        test_reset();
        test_read_write();
        test_hw_window();
        test_hd_window();
        test_overflow();
        test_full_push_pop();
        test_abort();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ibex_register_file_hw_mon.md
Name: ibex_register_file_hw_mon

Overview:
- Flip-flop RISC-V register file with integrated Hamming-weight/Hamming-distance leakage monitor; drop-in for the FF register file in ID stage, plus a monitor stream port.
- Monitor accumulates a per-cycle leakage metric over a programmable window and pushes window sums into a small FIFO drained via valid/ready, replacing simulation-only file dumps with synthesizable hardware usable on FPGA.

Parameters:
RV32E, 0, 1 = 16 registers (4-bit addressing), 0 = 32 registers
DataWidth, 32, register word width
NumReadPorts, 2, number of combinational read ports (1..3)
DummyInstructions, 0, 1 = R0 is a real register written only by dummy instructions
WordZeroVal, '0, reset value of all registers and R0 read value
WindowLen, 16, cycles per accumulation window (>=1)
FifoDepth, 4, sample FIFO entries (power of two, >=2)

Ports:
clk_i  in  1  clock
rst_ni  in  1  async active-low reset
dummy_instr_id_i  in  1  read-side dummy-instruction flag
dummy_instr_wb_i  in  1  write-side dummy-instruction flag
raddr_i  in  NumReadPorts*5  packed read addresses, port k at [5k+:5]
rdata_o  out  NumReadPorts*DataWidth  packed read data
waddr_a_i  in  5  write address
wdata_a_i  in  DataWidth  write data
we_a_i  in  1  write enable
mon_en_i  in  1  monitor enable
mon_clr_i  in  1  sync clear of monitor state
mon_mode_i  in  1  0 = HW of selected register, 1 = HD of committed writes
mon_addr_i  in  5  register selected in mode 0
sample_valid_o  out  1  FIFO non-empty
sample_ready_i  in  1  consumer accepts head sample
sample_data_o  out  SW  head window sum, SW = $clog2(WindowLen*DataWidth+1)
overflow_o  out  1  sticky: a window sum was dropped because FIFO full

Behaviour:
- Clock clk_i, reset rst_ni asynchronous active-low. Reset: all register flops = WordZeroVal, FIFO empty, sample_valid_o=0, sample_data_o=0, overflow_o=0, FSM IDLE, accumulator and window counter 0.
- Addressing: only low ADDR_WIDTH bits (4 if RV32E else 5) of every address used. Write at posedge when we_a_i and decoded address != 0; read combinational from flop outputs (no write-to-read bypass; new value visible the cycle after write).
- R0: reads WordZeroVal. With DummyInstructions: separate flop written when we_a_i & dummy_instr_wb_i; read returns it only when dummy_instr_id_i, else WordZeroVal.
- Metric m per cycle: mode 0 = popcount of current flop value of mon_addr (R0 -> popcount(WordZeroVal)); mode 1 = popcount(old ^ wdata_a_i) when a non-R0 write commits this cycle, else 0. Dummy R0 writes count in mode 1 against dummy R0 flop.
- FSM IDLE/ACCUM. IDLE -> ACCUM when mon_en_i=1: latch mon_mode_i and mon_addr_i, accumulator = m of that cycle, count = 1. ACCUM: acc += m, count++ each cycle. Mode/addr changes ignored until next window.
- Window end: the cycle count reaches WindowLen, final sum (including that cycle's m) pushed to FIFO at that edge; acc/count restart; stay ACCUM if mon_en_i else IDLE. WindowLen=1 pushes every enabled cycle.
- mon_en_i low in ACCUM: partial window discarded, -> IDLE; FIFO untouched.
- FIFO: push and pop in same cycle when full -> both succeed, no overflow. Push when full and no pop -> sample dropped, overflow_o set sticky. Pop when sample_valid_o & sample_ready_i. sample_data_o = head entry, 0 when empty.
- mon_clr_i (priority over everything in monitor): FIFO flushed, overflow_o cleared, FSM IDLE, acc/count 0 at next edge. Does not affect register contents.
- Accumulator width SW; no saturation needed (sum bounded by WindowLen*DataWidth).

Test Plan:
- Reset, then write x15=0xFFFF_0000, read ports 0/1 at 15 and 0 -> 0xFFFF_0000 and 0 the cycle after write; same-cycle read shows old value.
- Mode 0, mon_addr=15 holding 0x0000_00FF, WindowLen=16, enable 16 cycles, ready=1 -> one sample 128, sample_valid_o high one cycle.
- Mode 1: x5=0x0F0F_0F0F then write 0xF0F0_F0F0 inside window, no other writes -> window sum 32; write to x0 contributes 0.
- ready=0, FifoDepth=4, run 5 windows -> 4 samples held, overflow_o=1; pop all -> original first four in order; mon_clr_i -> overflow_o=0, valid=0.
- Drop mon_en_i after 7 of 16 cycles -> no sample; re-enable -> fresh 16-cycle window with newly latched mon_addr.
- Assert rst_ni low mid-window with 2 samples queued -> all outputs return to reset values asynchronously; registers read WordZeroVal.
